// File: rtl/plic_pkg.sv
// Shared constants and helpers for the PLIC register-port arbiter.
// PLIC register offsets, requester index type and a one-hot decode helper.
package plic_pkg;

    localparam int unsigned PLIC_MAX_REQ = 4;

    localparam logic [25:0] PLIC_PRIO_BASE_OFFSET = 26'h000_0000;
    localparam logic [25:0] PLIC_ENABLE_OFFSET    = 26'h000_2000;
    localparam logic [25:0] PLIC_THRESHOLD_OFFSET = 26'h020_0000;
    localparam logic [25:0] PLIC_CLAIM_OFFSET     = 26'h020_0004;

    typedef logic [1:0] req_idx_t;

    function automatic req_idx_t onehot_idx(input logic [PLIC_MAX_REQ-1:0] oh);
        req_idx_t idx = '0;
        for (int i = 0; i < int'(PLIC_MAX_REQ); i++) begin
            if (oh[i]) idx = req_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/plic_rr_arb.sv
// Generic NREQ-way round-robin grant with a request mask.
// Search starts one past the last accepted winner; pointer moves only on accept.
module plic_rr_arb
    import plic_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] mask_i,
    input  logic            accept_i,
    output logic [NREQ-1:0] grant_o
);

    req_idx_t        last_q;
    req_idx_t        last_d;
    logic [NREQ-1:0] elig;
    logic            found;

    assign elig = req_i & ~mask_i;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        last_d  = last_q;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && elig[i] && (i == (int'(last_q) + k) % NREQ)) begin
                    found      = 1'b1;
                    grant_o[i] = 1'b1;
                    last_d     = req_idx_t'(i);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_q <= req_idx_t'(NREQ - 1);
        end else if (accept_i && found) begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/plic_reg_arbiter.sv
// Round-robin sharing of the PLIC MMIO register port between NREQ requesters.
// Define PLIC_ARB_CLAIM_LOCK_EN to serialise claim/complete ownership.
module plic_reg_arbiter
    import plic_pkg::*;
#(
    parameter int          NREQ       = 2,
    parameter logic [25:0] CLAIM_ADDR = PLIC_CLAIM_OFFSET
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [NREQ-1:0]    req_valid_i,
    output logic [NREQ-1:0]    req_ready_o,
    input  logic [NREQ*32-1:0] req_addr_i,
    input  logic [NREQ*32-1:0] req_wdata_i,
    input  logic [NREQ-1:0]    req_we_i,
    output logic [NREQ-1:0]    rsp_valid_o,
    output logic [31:0]        rsp_rdata_o,
    output logic               plic_en_o,
    output logic [31:0]        plic_addr_o,
    output logic [31:0]        plic_wdata_o,
    output logic               plic_we_o,
    input  logic [31:0]        plic_rdata_i
);

    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] rsp_valid_q;
    logic            rsp_we_q;

    plic_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .req_i    (req_valid_i),
        .mask_i   (mask),
        .accept_i (plic_en_o),
        .grant_o  (grant)
    );

    assign req_ready_o = grant;
    assign plic_en_o   = |grant;

    always_comb begin
        plic_addr_o  = '0;
        plic_wdata_o = '0;
        plic_we_o    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                plic_addr_o  = req_addr_i[i*32 +: 32];
                plic_wdata_o = req_wdata_i[i*32 +: 32];
                plic_we_o    = req_we_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rsp_valid_q <= '0;
            rsp_we_q    <= 1'b0;
        end else begin
            rsp_valid_q <= grant;
            rsp_we_q    <= plic_we_o;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = (|rsp_valid_q && !rsp_we_q) ? plic_rdata_i : '0;

`ifdef PLIC_ARB_CLAIM_LOCK_EN
    logic [NREQ-1:0] claim_hit;
    logic            gnt_claim;
    logic            inflight_q;
    logic            lock_q;
    logic            lock_d;
    req_idx_t        owner_q;
    req_idx_t        owner_d;
    req_idx_t        rsp_id;
    req_idx_t        gnt_id;

    assign rsp_id    = onehot_idx(PLIC_MAX_REQ'(rsp_valid_q));
    assign gnt_id    = onehot_idx(PLIC_MAX_REQ'(grant));
    assign gnt_claim = plic_en_o && (plic_addr_o[25:2] == CLAIM_ADDR[25:2]);

    // Claim-address accesses are masked for everyone but the claimer/owner.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            claim_hit[i] = (req_addr_i[i*32+2 +: 24] == CLAIM_ADDR[25:2]);
            mask[i]      = claim_hit[i] &&
                           ((inflight_q && (rsp_id != req_idx_t'(i))) ||
                            (lock_q && (owner_q != req_idx_t'(i))));
        end
    end

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        if (lock_q && gnt_claim && plic_we_o && (gnt_id == owner_q)) begin
            lock_d = 1'b0;
        end
        if (inflight_q && (plic_rdata_i != '0)) begin
            lock_d  = 1'b1;
            owner_d = rsp_id;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            inflight_q <= 1'b0;
            lock_q     <= 1'b0;
            owner_q    <= '0;
        end else begin
            inflight_q <= gnt_claim && !plic_we_o;
            lock_q     <= lock_d;
            owner_q    <= owner_d;
        end
    end
`else
    assign mask = '0;
`endif

endmodule

// File: tb/tb_plic_reg_arbiter.sv
// Randomised and directed bench for plic_reg_arbiter with a response scoreboard.
// Expected grants come from a round-robin/claim-lock reference model.
module tb_plic_reg_arbiter;

    localparam int          NREQ  = 2;
    localparam logic [31:0] CLAIM = 32'h0020_0004;
`ifdef PLIC_ARB_CLAIM_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic               clk_i = 1'b0;
    logic               rstn_i = 1'b0;
    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ-1:0]    req_ready_o;
    logic [NREQ*32-1:0] req_addr_i;
    logic [NREQ*32-1:0] req_wdata_i;
    logic [NREQ-1:0]    req_we_i;
    logic [NREQ-1:0]    rsp_valid_o;
    logic [31:0]        rsp_rdata_o;
    logic               plic_en_o;
    logic [31:0]        plic_addr_o;
    logic [31:0]        plic_wdata_o;
    logic               plic_we_o;
    logic [31:0]        plic_rdata_i = '0;

    plic_reg_arbiter #(
        .NREQ (NREQ)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_we_i     (req_we_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .plic_en_o    (plic_en_o),
        .plic_addr_o  (plic_addr_o),
        .plic_wdata_o (plic_wdata_o),
        .plic_we_o    (plic_we_o),
        .plic_rdata_i (plic_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Requester-side stimulus state
    logic [NREQ-1:0] tv = '0;
    logic [31:0]     ta [NREQ];
    logic [31:0]     td [NREQ];
    logic            tw [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_valid_i[i]          = tv[i];
            req_addr_i[i*32 +: 32]  = ta[i];
            req_wdata_i[i*32 +: 32] = td[i];
            req_we_i[i]             = tw[i];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    int          m_last;
    bit          m_infl;
    int          m_infl_id;
    bit          m_lock;
    int          m_owner;
    logic [31:0] pend_rd;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_claim(input logic [31:0] a);
        return a[25:2] == CLAIM[25:2];
    endfunction

    function automatic bit masked(input int i);
        if (!LOCK || !is_claim(ta[i])) return 1'b0;
        return (m_infl && m_infl_id != i) || (m_lock && m_owner != i);
    endfunction

    function automatic int model_winner();
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (tv[i] && !masked(i)) return i;
        end
        return -1;
    endfunction

    // One clock: drive, check grant/bus against the model, advance the model.
    task automatic cycle(input logic [31:0] nrd, output int win);
        int              w;
        logic [NREQ-1:0] exp_rdy;
        plic_rdata_i = pend_rd;
        @(negedge clk_i);
        w       = model_winner();
        exp_rdy = (w >= 0) ? (NREQ'(1) << w) : '0;
        check("ready", 128'(req_ready_o), 128'(exp_rdy));
        if (w >= 0)
            check("plic_bus", {plic_en_o, plic_we_o, plic_addr_o, plic_wdata_o},
                  {1'b1, tw[w], ta[w], td[w]});
        else
            check("plic_idle", {plic_en_o, plic_we_o, plic_addr_o, plic_wdata_o}, '0);
        if (LOCK) begin
            if (m_lock && w >= 0 && tw[w] && is_claim(ta[w]) && w == m_owner) m_lock = 1'b0;
            if (m_infl && pend_rd != 0) begin
                m_lock  = 1'b1;
                m_owner = m_infl_id;
            end
            m_infl    = (w >= 0) && !tw[w] && is_claim(ta[w]);
            m_infl_id = w;
        end
        if (w >= 0) begin
            m_last = w;
            sb.push_back('{w, tw[w] ? 32'h0 : nrd, cyc + 1});
        end
        @(posedge clk_i);
        #1;
        if (w >= 0) tv[w] = 1'b0;
        pend_rd = nrd;
        win     = w;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        tv     = '0;
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = '0;
            td[i] = '0;
            tw[i] = 1'b0;
        end
        plic_rdata_i = '0;
        pend_rd      = '0;
        sb.delete();
        m_last = NREQ - 1;
        m_infl = 1'b0;
        m_lock = 1'b0;
        @(negedge clk_i);
        check("reset_outputs", {req_ready_o, rsp_valid_o, rsp_rdata_o, plic_en_o, plic_addr_o,
                                plic_wdata_o, plic_we_o}, '0);
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
    endtask

    task automatic req(input int i, input logic [31:0] a, input logic we, input logic [31:0] d);
        tv[i] = 1'b1;
        ta[i] = a;
        tw[i] = we;
        td[i] = d;
    endtask

    // Scoreboard monitor: every strobe must match the oldest outstanding transfer, on time.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (rsp_valid_o != '0) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got rsp_valid=%b want none (cycle %0d)",
                             rsp_valid_o, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_valid", 128'(rsp_valid_o), 128'(NREQ'(1) << e.id));
                    check("rsp_rdata", 128'(rsp_rdata_o), 128'(e.data));
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                total++;
                bad++;
                $display("FAIL rsp_missing: got none want rsp for req%0d (cycle %0d)",
                         sb[0].id, cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          w;
        int          held;
        int          seq [6];
        logic [31:0] atab [6];
        atab = '{32'h0, 32'h4, 32'h8, 32'h2000, 32'h20_0000, 32'h20_0004};

        do_reset();

        // Single read
        req(0, 32'h2000, 1'b0, 32'h0);
        cycle(32'h5, w);
        check("single_grant", 128'(w), 128'(0));
        cycle($urandom, w);

        // Contention: alternation starting from requester 0
        do_reset();
        for (int k = 0; k < 6; k++) begin
            req(0, atab[$urandom_range(0, 3)], 1'b0, 32'h0);
            req(1, atab[$urandom_range(0, 3)], 1'b0, 32'h0);
            cycle($urandom, seq[k]);
        end
        for (int k = 0; k < 6; k++) check("contention_order", 128'(seq[k]), 128'(k % 2));
        tv = '0;
        cycle($urandom, w);

        // Back-to-back reads from requester 1
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req(1, 32'(k * 4), 1'b0, 32'h0);
            cycle($urandom, w);
            check("b2b_grant", 128'(w), 128'(1));
        end
        cycle($urandom, w);

        // Claim lock: req1 held off until req0 completes
        do_reset();
        req(0, CLAIM, 1'b0, 32'h0);
        cycle(32'd3, w);
        held = 0;
        for (int k = 1; k <= 8; k++) begin
            req(1, CLAIM, 1'b0, 32'h0);
            if (k == 4) req(0, CLAIM, 1'b1, 32'd3);
            cycle(32'h0, w);
            if (w == 1) break;
            held++;
        end
        check("lock_hold_cycles", 128'(held), LOCK ? 128'(4) : 128'(0));
        tv = '0;
        cycle(32'h0, w);
        cycle(32'h0, w);

        // Zero claim ID: no lock taken
        do_reset();
        req(0, CLAIM, 1'b0, 32'h0);
        cycle(32'h0, w);
        held = 0;
        for (int k = 1; k <= 8; k++) begin
            req(1, CLAIM, 1'b0, 32'h0);
            cycle(32'h0, w);
            if (w == 1) break;
            held++;
        end
        check("zero_claim_hold", 128'(held), LOCK ? 128'(1) : 128'(0));
        cycle(32'h0, w);

        // Reset mid-operation discards the in-flight response
        do_reset();
        req(0, 32'h4, 1'b0, 32'h0);
        cycle(32'h77, w);
        do_reset();
        cycle($urandom, w);
        req(0, 32'h8, 1'b0, 32'h0);
        req(1, 32'h8, 1'b0, 32'h0);
        cycle($urandom, w);
        check("post_reset_first", 128'(w), 128'(0));
        tv = '0;
        cycle($urandom, w);

        // Randomised traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] nrd;
            for (int i = 0; i < NREQ; i++) begin
                if (tv[i]) begin
                    if ($urandom_range(0, 9) == 0) tv[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    req(i, atab[$urandom_range(0, 5)], ($urandom_range(0, 2) == 0), $urandom);
                end
            end
            nrd = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 5));
            cycle(nrd, w);
        end
        tv = '0;
        cycle($urandom, w);
        cycle($urandom, w);
        check("scoreboard_drained", 128'(sb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
